sccb_ov7670_config: RTL and testbench

SCCB (I²C-like, write-only) initiator that programs the OV7670 camera's registers before pixel capture starts. On a start pulse it walks a fixed register table and emits one 3-phase write per entry: device ID, register address, data. It drives the camera's SIOC clock and open-drain SIOD line. It sits beside the capture interface, and its `pronto` output gates the capture `iniciar`.

---
 rtl/sccb_ov7670_pkg.sv | 36 +++
 rtl/ov7670_reg_rom.sv | 19 +
 rtl/sccb_ov7670_config.sv | 179 +++++++++++++++++
 tb/tb_sccb_ov7670_config.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_ov7670_pkg.sv
// Shared types, state codes and the OV7670 register table
// for the SCCB configuration initiator.
package sccb_ov7670_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_START = 4'd2,
        ST_BITS  = 4'd3,
        ST_STOP  = 4'd4,
        ST_GAP   = 4'd5,
        ST_WAIT  = 4'd6,
        ST_DONE  = 4'd7
    } state_t;

    localparam int N_REGS     = 6;
    localparam int IDX_W      = 3;
    localparam int FRAME_BITS = 27;

    typedef struct packed {
        logic       wait_en;
        logic [7:0] addr;
        logic [7:0] data;
    } reg_entry_t;

    // First entry is the soft reset (COM7=0x80); it needs a settle time.
    localparam reg_entry_t REG_TABLE [N_REGS] = '{
        '{1'b1, 8'h12, 8'h80},
        '{1'b0, 8'h12, 8'h04},
        '{1'b0, 8'h40, 8'hD0},
        '{1'b0, 8'h11, 8'h01},
        '{1'b0, 8'h0C, 8'h04},
        '{1'b0, 8'h3E, 8'h19}
    };

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational lookup of the OV7670 register table:
// index -> {wait, addr, data}.
module ov7670_reg_rom
    import sccb_ov7670_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [16:0]      entry
);

    always_comb begin
        entry = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                entry = REG_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/sccb_ov7670_config.sv
// SCCB write-only initiator that walks the OV7670 register
// table on a start pulse and flags when it is finished.
module sccb_ov7670_config
    import sccb_ov7670_pkg::*;
#(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         SCCB_FREQ  = 100_000,
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         RESET_WAIT = 50_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       SDIOC,
    output logic       SDIOD_oe,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TICK = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int TW   = $clog2(TICK + 1);
    localparam int WW   = $clog2(RESET_WAIT + 1);

    state_t                  state;
    state_t                  state_n;
    logic [TW-1:0]           tick_cnt;
    logic [1:0]              q;
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic [WW-1:0]           wait_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    hold_f;
    reg_entry_t              rom_q;

    logic tick;
    logic q_end;
    logic on_bus;
    logic last;
    logic wait_done;
    logic adv;
    logic start_req;

    ov7670_reg_rom u_rom (
        .idx   (idx),
        .entry (rom_q)
    );

    assign tick      = (tick_cnt == TW'(TICK - 1));
    assign q_end     = tick && (q == 2'd3);
    assign on_bus    = (state == ST_START) || (state == ST_BITS) ||
                       (state == ST_STOP)  || (state == ST_GAP);
    assign last      = (idx == IDX_W'(N_REGS - 1));
    assign wait_done = (wait_cnt == WW'(RESET_WAIT - 1));
    assign start_req = (state == ST_IDLE) && iniciar;
    assign adv       = ((state == ST_GAP) || (state == ST_WAIT)) &&
                       (state_n == ST_LOAD);

    assign ocupado   = (state != ST_IDLE);
    assign db_estado = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Line levels are decoded from the registered state so that an
    // asynchronous reset releases both lines without waiting a clock.
    always_comb begin
        state_n  = state;
        SDIOC    = 1'b1;
        SDIOD_oe = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iniciar) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_n = ST_START;
            end
            ST_START: begin
                SDIOC    = (q != 2'd3);
                SDIOD_oe = (q != 2'd0);
                if (q_end) begin
                    state_n = ST_BITS;
                end
            end
            ST_BITS: begin
                SDIOC    = q[1];
                SDIOD_oe = ~shreg[FRAME_BITS-1];
                if (q_end && (bit_cnt == 5'(FRAME_BITS - 1))) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                SDIOC    = (q != 2'd0);
                SDIOD_oe = ~q[1];
                if (q_end) begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (q_end) begin
                    if (hold_f) begin
                        state_n = ST_WAIT;
                    end else if (last) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_n = last ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            q        <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            hold_f   <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            if (on_bus) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    q <= q + 2'd1;
                end
            end else begin
                tick_cnt <= '0;
                q        <= '0;
            end

            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;

            // 9th bit of each byte is a 1 so the line is released.
            if (state == ST_LOAD) begin
                shreg   <= {DEV_ID, 1'b1, rom_q.addr, 1'b1,
                            rom_q.data, 1'b1};
                bit_cnt <= '0;
                hold_f  <= rom_q.wait_en;
            end else if ((state == ST_BITS) && q_end) begin
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (start_req) begin
                idx <= '0;
            end else if (adv) begin
                idx <= idx + 1'b1;
            end

            if (state == ST_DONE) begin
                pronto <= 1'b1;
            end else if (start_req) begin
                pronto <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sccb_ov7670_config.sv
// Randomised bench: decodes the SCCB bus and compares it with
// a table-level model of the expected transactions and timing.
module tb_sccb_ov7670_config;

    localparam int CLK_FREQ   = 400_000;
    localparam int SCCB_FREQ  = 100_000;
    localparam int RESET_WAIT = 20;
    localparam int TICK       = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int NR         = 6;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       iniciar = 1'b0;
    logic       SDIOC;
    logic       SDIOD_oe;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;

    int ref_wait [NR] = '{1, 0, 0, 0, 0, 0};
    int ref_addr [NR] = '{'h12, 'h12, 'h40, 'h11, 'h0C, 'h3E};
    int ref_data [NR] = '{'h80, 'h04, 'hD0, 'h01, 'h04, 'h19};

    logic [23:0] tx_q  [$];
    int          tx_st [$];
    int          tx_sp [$];
    int          mal = 0;

    sccb_ov7670_config #(
        .CLK_FREQ   (CLK_FREQ),
        .SCCB_FREQ  (SCCB_FREQ),
        .DEV_ID     (8'h42),
        .RESET_WAIT (RESET_WAIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .SDIOC     (SDIOC),
        .SDIOD_oe  (SDIOD_oe),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency();
        int s = 2;
        for (int i = 0; i < NR; i++) begin
            s += 1 + 120 * TICK;
            if (ref_wait[i] != 0) s += RESET_WAIT;
        end
        return s;
    endfunction

    // Bus decoder: start/stop are SIOD edges with SIOC high;
    // data bits are sampled on SIOC rising edges.
    initial begin
        logic        pc, pd, c, d, active;
        logic [27:0] sh;
        int          nb, cyc, st_t;
        pc = 1'b1; pd = 1'b1; active = 1'b0;
        sh = '0; nb = 0; cyc = 0; st_t = 0;
        forever begin
            @(negedge clock);
            cyc++;
            c = SDIOC;
            d = ~SDIOD_oe;
            if (!reset) begin
                active = 1'b0;
                nb = 0;
            end else if (pc && c && pd && !d) begin
                if (active) mal++;
                active = 1'b1;
                nb = 0;
                st_t = cyc;
            end else if (pc && c && !pd && d) begin
                if (!active || nb != 28 || sh[19] != 1'b1 ||
                    sh[10] != 1'b1 || sh[1] != 1'b1) begin
                    mal++;
                end else begin
                    tx_q.push_back({sh[27:20], sh[18:11], sh[9:2]});
                    tx_st.push_back(st_t);
                    tx_sp.push_back(cyc);
                end
                active = 1'b0;
            end else if (!pc && c && active) begin
                sh = {sh[26:0], d};
                nb++;
            end
            pc = c;
            pd = d;
        end
    end

    task automatic run_table(input int spur, input string nm);
        int base = tx_q.size();
        int mal0 = mal;
        int n    = 0;
        bit done = 1'b0;
        int got_n;
        @(negedge clock);
        iniciar = 1'b1;
        while (!done && n < 5000) begin
            @(negedge clock);
            n++;
            iniciar = (n == spur);
            if (n == 1) begin
                check_eq({nm, "_pronto_clr"}, pronto, 1'b0);
                check_eq({nm, "_busy"}, ocupado, 1'b1);
                check_eq({nm, "_load_st"}, db_estado, 4'd1);
            end
            if (pronto) done = 1'b1;
        end
        iniciar = 1'b0;
        check_eq({nm, "_latency"}, n, exp_latency());
        got_n = tx_q.size() - base;
        check_eq({nm, "_ntx"}, got_n, NR);
        for (int i = 0; i < NR; i++) begin
            if (base + i < tx_q.size()) begin
                check_eq($sformatf("%s_tx%0d", nm, i), tx_q[base + i],
                         {8'h42, 8'(ref_addr[i]), 8'(ref_data[i])});
            end
        end
        for (int i = 1; i < NR; i++) begin
            if (base + i < tx_q.size()) begin
                check_eq($sformatf("%s_gap%0d", nm, i),
                         tx_st[base + i] - tx_sp[base + i - 1],
                         7 * TICK + 1 +
                         ((ref_wait[i - 1] != 0) ? RESET_WAIT : 0));
            end
        end
        check_eq({nm, "_malformed"}, mal - mal0, 0);
        check_eq({nm, "_idle_st"}, {ocupado, db_estado}, 5'd0);
    endtask

    task automatic reset_mid(input int rpt);
        int n = 0;
        @(negedge clock);
        iniciar = 1'b1;
        while (n < rpt) begin
            @(negedge clock);
            n++;
            iniciar = 1'b0;
        end
        check_eq("pre_rst_bits", db_estado, 4'd3);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_lines", {SDIOC, SDIOD_oe}, 2'b10);
        check_eq("rst_state", {ocupado, pronto, db_estado}, 6'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat ($urandom_range(2, 30)) @(negedge clock);
        run_table(0, "after_rst");
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            check_eq("idle_hold",
                     {SDIOC, SDIOD_oe, ocupado, pronto, db_estado},
                     8'h80);
        end
        run_table(0, "run1");
        repeat ($urandom_range(5, 50)) @(negedge clock);
        check_eq("pronto_sticky", pronto, 1'b1);
        run_table(300, "spur300");
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 40)) @(negedge clock);
            run_table($urandom_range(2, 740), $sformatf("spur_r%0d", k));
        end
        repeat ($urandom_range(1, 40)) @(negedge clock);
        reset_mid($urandom_range(392, 494));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
